user_gcd_la: RTL and testbench



---
 rtl/user_gcd_la.sv | 107 ++++++++++
 tb/tb_user_gcd_la.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/user_gcd_la.sv
// Binary (Stein) GCD engine controlled over the logic-analyzer bus.
// Operands and start/abort arrive on la_data_in; result, status and iteration count return on la_data_out.
module user_gcd_la #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ITER_W = 8
) (
   input  logic         clock,
   input  logic         resetb,
   input  logic [127:0] la_data_in,
   input  logic [127:0] la_oenb,
   output logic [127:0] la_data_out
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  a, a_n, b, b_n, result, result_n;
   logic [5:0]        k, k_n;
   logic [ITER_W-1:0] iter, iter_n;
   logic              start_d;
   logic              start_q, start_pulse, abort_q;
   logic              unused_la;

   assign start_q     = la_data_in[64] & ~la_oenb[64];
   assign abort_q     = la_data_in[65] & ~la_oenb[65];
   assign start_pulse = start_q & ~start_d;
   assign unused_la   = ^{la_data_in[127:66], la_oenb[127:66], la_oenb[63:0]};

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state   <= IDLE;
         start_d <= 1'b0;
         a       <= '0;
         b       <= '0;
         k       <= '0;
         iter    <= '0;
         result  <= '0;
      end else begin
         state   <= state_n;
         start_d <= start_q;
         a       <= a_n;
         b       <= b_n;
         k       <= k_n;
         iter    <= iter_n;
         result  <= result_n;
      end
   end

   always_comb begin
      state_n  = state;
      a_n      = a;
      b_n      = b;
      k_n      = k;
      iter_n   = iter;
      result_n = result;
      if (abort_q) begin
         state_n  = IDLE;
         result_n = '0;
         iter_n   = '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start_pulse) begin
                  a_n     = la_data_in[WIDTH-1:0];
                  b_n     = la_data_in[32 +: WIDTH];
                  k_n     = '0;
                  iter_n  = '0;
                  state_n = CALC;
               end
            end
            CALC: begin
               // Counter saturates; the terminating cycle is counted too.
               if (iter != '1) iter_n = iter + ITER_W'(1);
               if (a == '0) begin
                  result_n = b << k;
                  state_n  = DONE;
               end else if (b == '0) begin
                  result_n = a << k;
                  state_n  = DONE;
               end else if (!a[0] && !b[0]) begin
                  a_n = a >> 1;
                  b_n = b >> 1;
                  k_n = k + 6'd1;
               end else if (!a[0]) begin
                  a_n = a >> 1;
               end else if (!b[0]) begin
                  b_n = b >> 1;
               end else if (a >= b) begin
                  a_n = (a - b) >> 1;
               end else begin
                  b_n = (b - a) >> 1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      la_data_out                 = '0;
      la_data_out[WIDTH-1:0]      = result;
      la_data_out[32]             = (state == DONE);
      la_data_out[33]             = (state == CALC);
      la_data_out[34 +: ITER_W]   = iter;
   end

endmodule

// File: tb/tb_user_gcd_la.sv
// Directed self-checking bench for user_gcd_la: regression vectors, zero and
// power-of-two corners, start edge handling, LA gating, abort and async reset.
module tb_user_gcd_la;

   logic         clock = 1'b0;
   logic         resetb;
   logic [127:0] la_data_in;
   logic [127:0] la_oenb;
   logic [127:0] la_data_out;

   int checks   = 0;
   int failures = 0;

   logic [31:0] res;
   logic        done, busy;
   logic [7:0]  iter;

   assign res  = la_data_out[31:0];
   assign done = la_data_out[32];
   assign busy = la_data_out[33];
   assign iter = la_data_out[41:34];

   always #5 clock = ~clock;

   user_gcd_la #(.WIDTH(32), .ITER_W(8)) dut (
      .clock       (clock),
      .resetb      (resetb),
      .la_data_in  (la_data_in),
      .la_oenb     (la_oenb),
      .la_data_out (la_data_out)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (la_data_out[32] !== 1'b1 && n < 80) begin
         tick();
         n++;
      end
   endtask

   task automatic run_gcd(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] exp_res, input int exp_iter);
      int n;
      la_data_in[31:0]  = opa;
      la_data_in[63:32] = opb;
      la_data_in[64]    = 1'b1;
      tick();
      check({tag, "_busy_start"}, busy, 1);
      check({tag, "_done_start"}, done, 0);
      wait_done(n);
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, n <= 66, 1);
      check({tag, "_result"}, res, exp_res);
      check({tag, "_busy_end"}, busy, 0);
      if (exp_iter >= 0) begin
         check({tag, "_iter"}, iter, exp_iter);
         check({tag, "_cycles"}, n, exp_iter);
      end
      la_data_in[64] = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int rises;
      logic prev;

      la_data_in = '0;
      la_oenb    = '0;
      resetb     = 1'b1;
      #3 resetb  = 1'b0;
      #1 check("reset_async", la_data_out, 0);
      tick();
      tick();
      check("reset_held", la_data_out, 0);
      @(negedge clock) resetb = 1'b1;
      tick();
      check("idle_after_reset", la_data_out, 0);

      // Regression vectors, back to back
      run_gcd("v1", 32'd10312050,   32'd29460792,   32'd138, -1);
      run_gcd("v2", 32'd1993627629, 32'd1177417612, 32'd7,   -1);
      run_gcd("v3", 32'd2097015289, 32'd3812041926, 32'd1,   -1);
      run_gcd("v4", 32'd1924134885, 32'd3151131255, 32'd135, -1);
      run_gcd("v5", 32'd992211318,  32'd512609597,  32'd1,   -1);

      // Zero operands
      run_gcd("z00", 32'd0,  32'd0,  32'd0,  1);
      run_gcd("z0x", 32'd0,  32'd12, 32'd12, 1);
      run_gcd("zx0", 32'd12, 32'd0,  32'd12, 1);

      // Powers of two: 31 halvings, one subtract, one terminate
      run_gcd("p2",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 33);
      run_gcd("pmax", 32'hFFFF_FFFF, 32'd1,         32'd1,         -1);

      repeat (3) tick();
      check("done_hold", done, 1);
      check("result_hold", res, 1);

      // Start held high for 200 cycles
      la_data_in[31:0]  = 32'd48;
      la_data_in[63:32] = 32'd18;
      la_data_in[64]    = 1'b1;
      rises = 0;
      prev  = 1'b0;
      repeat (200) begin
         tick();
         if (busy && !prev) rises++;
         prev = busy;
      end
      check("held_rises", rises, 1);
      check("held_done", done, 1);
      check("held_result", res, 6);
      check("held_iter", iter, 7);
      la_data_in[64] = 1'b0;
      tick();

      // Start re-pulsed mid-computation with new operands
      la_data_in[31:0]  = 32'd1000;
      la_data_in[63:32] = 32'd600;
      la_data_in[64]    = 1'b1;
      tick();
      la_data_in[64] = 1'b0;
      tick();
      la_data_in[31:0]  = 32'd7;
      la_data_in[63:32] = 32'd5;
      la_data_in[64]    = 1'b1;
      tick();
      check("repulse_busy", busy, 1);
      la_data_in[64] = 1'b0;
      wait_done(n);
      check("repulse_done", done, 1);
      check("repulse_result", res, 200);
      check("repulse_iter", iter, 7);

      // Start gated by la_oenb
      la_oenb[64] = 1'b1;
      la_data_in[31:0]  = 32'd48;
      la_data_in[63:32] = 32'd18;
      for (int i = 0; i < 4; i++) begin
         la_data_in[64] = 1'b1;
         tick();
         check("gated_busy_hi", busy, 0);
         la_data_in[64] = 1'b0;
         tick();
         check("gated_busy_lo", busy, 0);
      end
      check("gated_result", res, 200);
      la_oenb[64] = 1'b0;
      tick();

      // Abort mid-computation
      la_data_in[31:0]  = 32'h8000_0000;
      la_data_in[63:32] = 32'h8000_0000;
      la_data_in[64]    = 1'b1;
      tick();
      la_data_in[64] = 1'b0;
      repeat (5) tick();
      check("abort_pre_busy", busy, 1);
      la_data_in[65] = 1'b1;
      tick();
      check("abort_out", la_data_out, 0);
      la_data_in[65] = 1'b0;
      tick();
      check("abort_idle", la_data_out, 0);

      // Asynchronous reset mid-computation, start held through reset
      la_data_in[31:0]  = 32'hFFFF_FFFF;
      la_data_in[63:32] = 32'd1;
      la_data_in[64]    = 1'b1;
      tick();
      repeat (3) tick();
      check("areset_pre_busy", busy, 1);
      #1 resetb = 1'b0;
      #1 check("areset_out", la_data_out, 0);
      la_data_in[31:0]  = 32'd48;
      la_data_in[63:32] = 32'd18;
      @(negedge clock) resetb = 1'b1;
      tick();
      check("areset_restart_busy", busy, 1);
      wait_done(n);
      check("areset_done", done, 1);
      check("areset_result", res, 6);
      check("areset_iter", iter, 7);
      la_data_in[64] = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
